// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_pkg
// Purpose  : Shared channel constants and types for the stream demultiplexer.
// Revision : 1.0 - initial release
// ============================================================================
package demux_pkg;

  localparam int NUM_CHANNELS  = 4;
  localparam int CH_ADDR_WIDTH = 2;

  typedef logic [CH_ADDR_WIDTH-1:0] ch_addr_t;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/demux_fifo.sv
`default_nettype none
// ============================================================================
// Module   : demux_fifo
// Purpose  : Per-channel synchronous FIFO with show-ahead read data.
// Revision : 1.0 - initial release
// ============================================================================
module demux_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int                 C_PTR_W   = $clog2(DEPTH);
  localparam logic [C_PTR_W:0]   C_DEPTH   = (C_PTR_W + 1)'(DEPTH);
  localparam logic [C_PTR_W-1:0] C_PTR_ONE = C_PTR_W'(1);
  localparam logic [C_PTR_W:0]   C_CNT_ONE = (C_PTR_W + 1)'(1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr;
  logic [C_PTR_W-1:0] r_rd_ptr;
  logic [C_PTR_W:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign full     = (r_count == C_DEPTH);
  assign empty    = (r_count == '0);
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;
  assign pop_data = r_mem[r_rd_ptr];

  // Storage is cleared too so the read port shows zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : demux_fifo
`default_nettype wire

// File: rtl/stream_demultiplexer.sv
`default_nettype none
// ============================================================================
// Module   : stream_demultiplexer
// Purpose  : 1-to-4 valid/ready stream demux with a FIFO per output channel.
// Revision : 1.0 - initial release
// ============================================================================
module stream_demultiplexer
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        address0,
  input  logic                        address1,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [NUM_CHANNELS*WIDTH-1:0] out_data,
  output logic [NUM_CHANNELS-1:0]     out_valid,
  input  logic [NUM_CHANNELS-1:0]     out_ready
);

  ch_addr_t                w_ch;
  logic [NUM_CHANNELS-1:0] w_full;
  logic [NUM_CHANNELS-1:0] w_empty;
  logic [NUM_CHANNELS-1:0] w_push;
  logic [NUM_CHANNELS-1:0] w_pop;

  assign w_ch = {address1, address0};
  // Readiness follows the registered fill level only; a same-cycle pop does not free a slot.
  assign in_ready = !w_full[w_ch];

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    assign w_push[k]    = in_valid && in_ready && (w_ch == ch_addr_t'(k));
    assign w_pop[k]     = out_ready[k] && !w_empty[k];
    assign out_valid[k] = !w_empty[k];

    demux_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (w_push[k]),
      .push_data (in_data),
      .full      (w_full[k]),
      .pop       (w_pop[k]),
      .pop_data  (out_data[k*WIDTH +: WIDTH]),
      .empty     (w_empty[k])
    );
  end

endmodule : stream_demultiplexer
`default_nettype wire

// File: tb/tb_stream_demultiplexer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_demultiplexer
// Purpose  : Scoreboard bench for stream_demultiplexer (WIDTH=8, DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_demultiplexer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [WIDTH-1:0]  in_data;
  logic              address0;
  logic              address1;
  logic              in_valid;
  logic              in_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]        out_valid;
  logic [3:0]        out_ready;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q [4][$];
  logic done;

  stream_demultiplexer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .address0  (address0),
    .address1  (address1),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Handshakes are sampled mid-cycle; they complete at the following rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          if (exp_q[k].size() == 0) check($sformatf("unexpected_ch%0d", k), 32'd1, 32'd0);
          else check($sformatf("data_ch%0d", k), 32'(out_data[k*WIDTH +: WIDTH]),
                     32'(exp_q[k].pop_front()));
        end
      end
      if (in_valid && in_ready) exp_q[{address1, address0}].push_back(in_data);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [1:0] ch, input logic [WIDTH-1:0] d);
    int n = 0;
    {address1, address0} = ch;
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic int pending();
    return exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size();
  endfunction

  task automatic drain();
    int n = 0;
    out_ready = 4'hF;
    while (pending() != 0 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("drain_pending", 32'(pending()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    address0  = 1'b0;
    address1  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'h0;
    done      = 1'b0;
    #2;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Mid-stream asynchronous reset
    send(2'd0, 8'h11);
    send(2'd2, 8'h22);
    check("pre_rst_valid", 32'(out_valid), 32'h5);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) exp_q[k].delete();
    @(posedge clk);
    #1 reset = 1'b0;

    // First word after release, one-cycle latency
    send(2'd0, 8'hA5);
    check("post_rst_valid", 32'(out_valid), 32'h1);
    check("post_rst_data", 32'(out_data[7:0]), 32'hA5);
    drain();

    // Routing sweep
    begin
      logic [WIDTH-1:0] words [4];
      words[0] = 8'h10; words[1] = 8'h21; words[2] = 8'h32; words[3] = 8'h43;
      out_ready = 4'hF;
      for (int k = 0; k < 4; k++) begin
        send(2'(k), words[k]);
        check($sformatf("route_valid_ch%0d", k), 32'(out_valid), 32'(1 << k));
        check($sformatf("route_data_ch%0d", k), 32'(out_data[k*WIDTH +: WIDTH]), 32'(words[k]));
      end
    end
    drain();

    // Backpressure on ch2, ch1 unaffected
    out_ready = 4'b1011;
    send(2'd2, 8'h01);
    send(2'd2, 8'h02);
    send(2'd1, 8'h55);
    check("bp_ch1_valid", 32'(out_valid[1]), 32'd1);
    fork
      send(2'd2, 8'h03);
      begin
        repeat (3) @(negedge clk);
        check("bp_stall", 32'(in_ready), 32'd0);
        check("bp_ch2_valid", 32'(out_valid[2]), 32'd1);
        @(posedge clk);
        #1 out_ready[2] = 1'b1;
      end
    join
    drain();

    // Simultaneous push and pop on ch3
    out_ready = 4'h0;
    send(2'd3, 8'h61);
    out_ready[3] = 1'b1;
    send(2'd3, 8'h62);
    check("pp_valid", 32'(out_valid[3]), 32'd1);
    check("pp_data", 32'(out_data[3*WIDTH +: WIDTH]), 32'h62);
    @(posedge clk);
    #1;
    check("pp_count_one", 32'(out_valid[3]), 32'd0);
    drain();

    // No pass-through on a full channel
    out_ready = 4'h0;
    send(2'd0, 8'h71);
    send(2'd0, 8'h72);
    out_ready[0] = 1'b1;
    fork
      send(2'd0, 8'h73);
      begin
        @(negedge clk);
        check("full_no_pass", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("full_next_ready", 32'(in_ready), 32'd1);
      end
    join
    drain();

    // Pointer wrap on ch1 with random consumer readiness
    out_ready = 4'h0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(2'd1, 8'(8'h80 + i));
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready[1] = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_stream_demultiplexer
`default_nettype wire

// File: doc/stream_demultiplexer.md
# stream_demultiplexer

Sequential 1-to-4 demultiplexer: the inverse of the team's 4:1 multiplexer. One valid/ready input stream carries data plus a 2-bit channel address (address1:address0). Each accepted word is steered into a per-channel FIFO, and each channel drives its own valid/ready output stream. The block sits between a single producer and four independent consumers, so a stalled consumer blocks only words addressed to that consumer.

## Interface
Parameters:
- WIDTH, 8, data bits per word
- DEPTH, 2, entries per channel FIFO; power of two, ≥2

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- in_data  input  WIDTH  input word
- address0  input  1  channel select LSB
- address1  input  1  channel select MSB
- in_valid  input  1  input word present
- in_ready  output  1  selected channel can accept
- out_data  output  4*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
- out_valid  output  4  channel k holds a word
- out_ready  input  4  consumer k accepts

## Operation
- Channel select: ch = {address1, address0}.
- in_ready = (count[ch] < DEPTH), purely combinational from current state and address.
  - No full-cycle pass-through: a pop on a full channel does not raise in_ready in the same cycle.
- Push: in_valid && in_ready at a rising edge writes in_data into FIFO[ch], advances wr_ptr[ch], and increments count[ch].
- Pop: out_valid[k] && out_ready[k] at a rising edge advances rd_ptr[k] and decrements count[k].
- Push and pop on the same channel in the same cycle: count is unchanged and both pointers advance.
- All four channels pop independently in the same cycle.
- out_valid[k] = (count[k] != 0).
- out_data slice k = mem[k][rd_ptr[k]], stable while out_valid[k] && !out_ready[k].
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Ordering: per channel, strict FIFO order. No ordering is guaranteed across channels.
- Producer rules: in_data and the address must be held stable while in_valid && !in_ready. Changing the address while stalled is a producer protocol violation; the block routes whatever address is present at the accepting edge.
- Consumer rules: out_ready may toggle freely. Asserting out_ready while out_valid=0 has no effect.
- Illegal operations never occur: no push into a full FIFO, no pop from an empty one.

## Timing
- Latency: a word accepted at edge N is visible on out_valid/out_data immediately after edge N, i.e. in cycle N+1. There is no bypass.
- Throughput per channel: one word per cycle sustained while the consumer keeps out_ready high.
- Throughput at the input: one word per cycle while destination channels are not full.
- Reset values (asserted asynchronously, held while reset=1):
  - out_valid = 4'b0000
  - out_data = 0
  - all counts and pointers = 0
  - in_ready = 1
- Reset mid-operation: all buffered words are discarded and out_valid drops without waiting for a clock. A transfer coinciding with the reset edge is lost.
- Release: the first rising edge after reset deasserts may accept a word.

## Structure
- Shared package demux_pkg:
  - NUM_CHANNELS = 4
  - CH_ADDR_WIDTH = 2
  - typedef ch_addr_t (2-bit channel index)
- Sub-module demux_fifo (params WIDTH, DEPTH):
  - ports clk, reset, push, push_data, full, pop, pop_data, empty
  - instantiated four times by generate
- The top level holds only the address decode, the in_ready mux, and push/pop gating.

## Test plan
- Reset check: assert reset mid-stream → out_valid=0000, out_data=0, in_ready=1 with no clock edge. After release, send 8'hA5 to ch0 → out_valid=0001 the next cycle, data A5.
- Routing sweep: send 8'h10, 8'h21, 8'h32, 8'h43 to ch0..ch3 with all out_ready=1 → each word appears only on its own slice, one cycle after acceptance.
- Backpressure, DEPTH=2: out_ready[2]=0, send 8'h01, 8'h02, 8'h03 to ch2 → third word sees in_ready=0 and stalls. Meanwhile a word for ch1 is still accepted immediately. Raise out_ready[2] → 01, 02, 03 delivered in order.
- Simultaneous push/pop: ch3 holds one word and out_ready[3]=1 while a new word for ch3 is pushed → count stays 1 and the order is preserved.
- Full-cycle rule: ch0 full, out_ready[0]=1 and in_valid=1 to ch0 in the same cycle → in_ready=0 that cycle and is accepted the next.
- Pointer wrap: stream 10 words through ch1 with random out_ready → all 10 received in order with no loss or duplication.
